// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_pkg
// Purpose  : Shared definitions for the pipeline sink: default data width,
//            checker state encoding, backpressure LFSR seed and step function.
// Ports    : none (package)
// Revision : 1.0  initial release
// ============================================================================
package pipeline_pkg;

  localparam int          c_data_w    = 32;
  localparam logic [15:0] c_lfsr_seed = 16'hACE1;

  // Feedback taps (polynomial x^16 + x^14 + x^13 + x^11 + 1), as bit indices
  localparam int c_tap_a = 15;
  localparam int c_tap_b = 13;
  localparam int c_tap_c = 12;
  localparam int c_tap_d = 10;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    RESYNC = 2'd2
  } chk_state_t;

  // One Fibonacci step: shift left, feedback enters at bit 0
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[c_tap_a] ^ l[c_tap_b] ^ l[c_tap_c] ^ l[c_tap_d]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/lfsr_stall_gen.sv
`default_nettype none
// ============================================================================
// Module   : lfsr_stall_gen
// Purpose  : Free-running 16-bit LFSR producing registered pseudo-random
//            backpressure. The LFSR steps every cycle whether or not
//            backpressure is enabled.
// Ports    : clk, reset (async, active-high)
//            stall_en      - enable backpressure
//            stall_thresh  - stall when next LFSR[3:0] < stall_thresh
//            stall_o       - registered stall to upstream
// Revision : 1.0  initial release
// ============================================================================
module lfsr_stall_gen
  import pipeline_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = c_lfsr_seed
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       stall_en,
  input  logic [3:0] stall_thresh,
  output logic       stall_o
);

  logic [15:0] r_lfsr;
  logic [15:0] w_lfsr_next;
  logic        r_stall;

  assign w_lfsr_next = lfsr_step(r_lfsr);

  // Decision uses the next LFSR value so stall_o lines up with the new state
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_lfsr  <= LFSR_SEED;
      r_stall <= 1'b0;
    end else begin
      r_lfsr  <= w_lfsr_next;
      r_stall <= stall_en & (w_lfsr_next[3:0] < stall_thresh);
    end
  end

  assign stall_o = r_stall;

endmodule
`default_nettype wire

// File: rtl/pipeline_sink.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_sink
// Purpose  : Terminal consumer of the valid/stall/flush stream. Applies
//            pseudo-random backpressure, accumulates a wrapping checksum and
//            a saturating word count, and checks that words follow a +1
//            sequence, resynchronising after every upstream flush.
// Ports    : clk, reset (async, active-high)
//            in_data/in_valid/in_flush - upstream stream
//            stall_o                   - backpressure to upstream
//            stall_en/stall_thresh     - backpressure control
//            seq_base                  - expected first word after reset/clear
//            clear                     - synchronous clear of stats/checker
//            sum_o/count_o/last_o      - statistics
//            err_o/err_cnt_o/first_err_o - sequence error reporting
//            state_o                   - checker state (IDLE/RUN/RESYNC)
// Revision : 1.0  initial release
// ============================================================================
module pipeline_sink
  import pipeline_pkg::*;
#(
  parameter int          DATA_W    = c_data_w,
  parameter int          CNT_W     = 16,
  parameter int          ECNT_W    = 8,
  parameter logic [15:0] LFSR_SEED = c_lfsr_seed
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  input  logic              in_flush,
  output logic              stall_o,
  input  logic              stall_en,
  input  logic [3:0]        stall_thresh,
  input  logic [DATA_W-1:0] seq_base,
  input  logic              clear,
  output logic [DATA_W-1:0] sum_o,
  output logic [CNT_W-1:0]  count_o,
  output logic [DATA_W-1:0] last_o,
  output logic              err_o,
  output logic [ECNT_W-1:0] err_cnt_o,
  output logic [DATA_W-1:0] first_err_o,
  output logic [1:0]        state_o
);

  localparam logic [DATA_W-1:0] c_one      = {{(DATA_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_cnt_one  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [ECNT_W-1:0] c_ecnt_one = {{(ECNT_W-1){1'b0}}, 1'b1};

  chk_state_t        r_state;
  chk_state_t        w_state_next;
  logic [DATA_W-1:0] r_exp;
  logic [DATA_W-1:0] w_exp_next;
  logic              w_cmp;
  logic [DATA_W-1:0] w_ref;
  logic              w_mismatch;
  logic              w_xfer;
  logic              w_stall;

  logic [DATA_W-1:0] r_sum;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_last;
  logic              r_err;
  logic [ECNT_W-1:0] r_err_cnt;
  logic [DATA_W-1:0] r_first_err;

  lfsr_stall_gen #(
    .LFSR_SEED (LFSR_SEED)
  ) u_stall_gen (
    .clk          (clk),
    .reset        (reset),
    .stall_en     (stall_en),
    .stall_thresh (stall_thresh),
    .stall_o      (w_stall)
  );

  // A flushed word is never accepted, even if valid and not stalled
  assign w_xfer = in_valid & ~w_stall & ~in_flush;

  // --------------------------------------------------------------------------
  // Sequence checker: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_exp   <= '0;
    end else begin
      r_state <= w_state_next;
      r_exp   <= w_exp_next;
    end
  end

  // --------------------------------------------------------------------------
  // Sequence checker: next state / compare selection
  // Priority clear > flush > transfer. The expectation always follows the
  // received word so a single glitch produces a single error.
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    w_exp_next   = r_exp;
    w_cmp        = 1'b0;
    w_ref        = r_exp;
    if (clear) begin
      w_state_next = IDLE;
    end else if (in_flush) begin
      if (r_state == RUN) begin
        w_state_next = RESYNC;
      end
    end else if (w_xfer) begin
      w_exp_next = in_data + c_one;
      case (r_state)
        IDLE: begin
          w_cmp        = 1'b1;
          w_ref        = seq_base;
          w_state_next = RUN;
        end
        RUN: begin
          w_cmp = 1'b1;
          w_ref = r_exp;
        end
        RESYNC: begin
          w_state_next = RUN;
        end
        default: begin
          w_state_next = IDLE;
        end
      endcase
    end
  end

  assign w_mismatch = w_cmp & (in_data != w_ref);

  // --------------------------------------------------------------------------
  // Statistics and error reporting
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_last      <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (clear) begin
      r_sum       <= '0;
      r_count     <= '0;
      r_last      <= '0;
      r_err       <= 1'b0;
      r_err_cnt   <= '0;
      r_first_err <= '0;
    end else if (w_xfer) begin
      r_sum  <= r_sum + in_data;
      r_last <= in_data;
      if (r_count != {CNT_W{1'b1}}) begin
        r_count <= r_count + c_cnt_one;
      end
      if (w_mismatch) begin
        if (r_err_cnt != {ECNT_W{1'b1}}) begin
          r_err_cnt <= r_err_cnt + c_ecnt_one;
        end
        if (!r_err) begin
          r_first_err <= in_data;
        end
        r_err <= 1'b1;
      end
    end
  end

  assign stall_o     = w_stall;
  assign sum_o       = r_sum;
  assign count_o     = r_count;
  assign last_o      = r_last;
  assign err_o       = r_err;
  assign err_cnt_o   = r_err_cnt;
  assign first_err_o = r_first_err;
  assign state_o     = r_state;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_sink.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_sink
// Purpose  : Directed self-checking bench for pipeline_sink. A second
//            instance with narrow counters shares the stimulus so that
//            counter saturation is reachable in few cycles.
// Revision : 1.0  initial release
// ============================================================================
module tb_pipeline_sink;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        in_flush = 1'b0;
  logic        stall_en = 1'b0;
  logic [3:0]  stall_thresh = 4'd0;
  logic [31:0] seq_base = 32'd100;
  logic        clear = 1'b0;

  logic        stall_o;
  logic [31:0] sum_o, last_o, first_err_o;
  logic [15:0] count_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;
  logic [1:0]  state_o;

  logic        s_stall_o;
  logic [31:0] s_sum_o, s_last_o, s_first_err_o;
  logic [3:0]  s_count_o;
  logic        s_err_o;
  logic [1:0]  s_err_cnt_o;
  logic [1:0]  s_state_o;

  int n_vec = 0;
  int n_err = 0;
  int stall_cycles = 0;
  int total_cycles = 0;

  always #5 clk = ~clk;

  pipeline_sink dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_flush(in_flush), .stall_o(stall_o), .stall_en(stall_en),
    .stall_thresh(stall_thresh), .seq_base(seq_base), .clear(clear),
    .sum_o(sum_o), .count_o(count_o), .last_o(last_o), .err_o(err_o),
    .err_cnt_o(err_cnt_o), .first_err_o(first_err_o), .state_o(state_o)
  );

  pipeline_sink #(.CNT_W(4), .ECNT_W(2)) dut_s (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_flush(in_flush), .stall_o(s_stall_o), .stall_en(stall_en),
    .stall_thresh(stall_thresh), .seq_base(seq_base), .clear(clear),
    .sum_o(s_sum_o), .count_o(s_count_o), .last_o(s_last_o), .err_o(s_err_o),
    .err_cnt_o(s_err_cnt_o), .first_err_o(s_first_err_o), .state_o(s_state_o)
  );

  // Reference backpressure model: x^16+x^14+x^13+x^11+1, shift left
  function automatic logic [15:0] m_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  logic [15:0] m_lfsr;
  logic        m_stall;
  wire  [15:0] m_nx = m_step(m_lfsr);

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_lfsr  <= 16'hACE1;
      m_stall <= 1'b0;
    end else begin
      m_lfsr  <= m_nx;
      m_stall <= stall_en && (m_nx[3:0] < stall_thresh);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Upstream stage: hold the word while stalled, release once taken
  task automatic send(input logic [31:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    chk("stall_model", {31'd0, stall_o}, {31'd0, m_stall});
    while (stall_o && n < 64) begin
      stall_cycles++;
      total_cycles++;
      tick();
      n++;
      chk("stall_model", {31'd0, stall_o}, {31'd0, m_stall});
    end
    if (stall_o) begin
      n_vec++;
      n_err++;
      $error("FAIL send_timeout: observed stall after %0d cycles, expected release", n);
    end
    total_cycles++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  initial begin
    // ---- reset state
    tick(); tick();
    reset = 1'b0;
    tick();
    chk("rst_stall",  {31'd0, stall_o}, 32'd0);
    chk("rst_sum",    sum_o, 32'd0);
    chk("rst_count",  {16'd0, count_o}, 32'd0);
    chk("rst_last",   last_o, 32'd0);
    chk("rst_err",    {31'd0, err_o}, 32'd0);
    chk("rst_errcnt", {24'd0, err_cnt_o}, 32'd0);
    chk("rst_first",  first_err_o, 32'd0);
    chk("rst_state",  {30'd0, state_o}, 32'd0);

    // ---- back-to-back 100..103, no backpressure
    for (int i = 100; i < 104; i++) send(i);
    chk("b2b_stall", {31'd0, stall_o}, 32'd0);
    chk("b2b_count", {16'd0, count_o}, 32'd4);
    chk("b2b_sum",   sum_o, 32'd406);
    chk("b2b_last",  last_o, 32'd103);
    chk("b2b_err",   {31'd0, err_o}, 32'd0);
    chk("b2b_state", {30'd0, state_o}, 32'd1);

    // ---- single glitch: 5,6,9,10
    seq_base = 32'd5;
    pulse_clear();
    chk("clr_state", {30'd0, state_o}, 32'd0);
    chk("clr_count", {16'd0, count_o}, 32'd0);
    send(5); send(6); send(9); send(10);
    chk("glitch_errcnt", {24'd0, err_cnt_o}, 32'd1);
    chk("glitch_first",  first_err_o, 32'd9);
    chk("glitch_err",    {31'd0, err_o}, 32'd1);
    chk("glitch_sum",    sum_o, 32'd30);

    // ---- flush resynchronisation
    seq_base = 32'd1;
    pulse_clear();
    send(1); send(2);
    in_flush = 1'b1;
    tick();
    in_flush = 1'b0;
    chk("flush_state", {30'd0, state_o}, 32'd2);
    send(50);
    chk("resync_state", {30'd0, state_o}, 32'd1);
    send(51);
    chk("flush_errcnt", {24'd0, err_cnt_o}, 32'd0);
    chk("flush_count",  {16'd0, count_o}, 32'd4);
    chk("flush_sum",    sum_o, 32'd104);

    // ---- flush with valid: word dropped
    in_flush = 1'b1; in_valid = 1'b1; in_data = 32'd7;
    tick();
    in_flush = 1'b0; in_valid = 1'b0;
    chk("flushv_count", {16'd0, count_o}, 32'd4);
    chk("flushv_sum",   sum_o, 32'd104);
    chk("flushv_state", {30'd0, state_o}, 32'd2);

    // ---- clear with valid: word discarded
    clear = 1'b1; in_valid = 1'b1; in_data = 32'd9;
    tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clrv_count", {16'd0, count_o}, 32'd0);
    chk("clrv_sum",   sum_o, 32'd0);
    chk("clrv_last",  last_o, 32'd0);
    chk("clrv_state", {30'd0, state_o}, 32'd0);

    // ---- sum wrap: FFFFFFFF + 1 = 0 (and 1 breaks the sequence)
    seq_base = 32'hFFFF_FFFF;
    send(32'hFFFF_FFFF);
    send(32'd1);
    chk("wrap_sum",    sum_o, 32'd0);
    chk("wrap_count",  {16'd0, count_o}, 32'd2);
    chk("wrap_errcnt", {24'd0, err_cnt_o}, 32'd1);
    chk("wrap_first",  first_err_o, 32'd1);

    // ---- repeated errors: 5 mismatches, narrow counter saturates at 3
    seq_base = 32'd0;
    pulse_clear();
    for (int i = 1; i <= 5; i++) send(i * 10);
    chk("errs_cnt",    {24'd0, err_cnt_o}, 32'd5);
    chk("errs_cnt_s",  {30'd0, s_err_cnt_o}, 32'd3);
    chk("errs_first",  first_err_o, 32'd10);
    chk("errs_last",   last_o, 32'd50);

    // ---- 1000 words under 50% backpressure
    pulse_clear();
    stall_en = 1'b1;
    stall_thresh = 4'd8;
    stall_cycles = 0;
    total_cycles = 0;
    for (int i = 0; i < 1000; i++) send(i);
    chk("bp_count",   {16'd0, count_o}, 32'd1000);
    chk("bp_count_s", {28'd0, s_count_o}, 32'd15);
    chk("bp_sum",     sum_o, 32'd499500);
    chk("bp_err",     {31'd0, err_o}, 32'd0);
    chk("bp_duty_ok", {31'd0, (stall_cycles * 100 > total_cycles * 35) &&
                              (stall_cycles * 100 < total_cycles * 65)}, 32'd1);

    // ---- threshold change visible after one cycle
    stall_thresh = 4'd0;
    tick();
    chk("thr0_stall", {31'd0, stall_o}, 32'd0);
    stall_thresh = 4'd15;
    tick();
    chk("thr15_stall", {31'd0, stall_o}, {31'd0, m_stall});
    stall_en = 1'b0;
    tick();
    chk("en0_stall", {31'd0, stall_o}, 32'd0);

    // ---- asynchronous reset mid-stream
    send(500); send(501);
    reset = 1'b1;
    #2;
    chk("arst_count", {16'd0, count_o}, 32'd0);
    chk("arst_sum",   sum_o, 32'd0);
    chk("arst_state", {30'd0, state_o}, 32'd0);
    #1;
    reset = 1'b0;
    tick();
    send(0);
    chk("arst_next_err",   {31'd0, err_o}, 32'd0);
    chk("arst_next_state", {30'd0, state_o}, 32'd1);
    chk("arst_next_count", {16'd0, count_o}, 32'd1);

    // ---- count saturation on the narrow instance
    pulse_clear();
    for (int i = 0; i < 17; i++) send(i);
    chk("sat_count",   {16'd0, count_o}, 32'd17);
    chk("sat_count_s", {28'd0, s_count_o}, 32'd15);
    chk("sat_sum",     sum_o, 32'd136);
    chk("sat_err",     {31'd0, err_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipeline_sink.md
# pipeline_sink

Terminal consumer stage placed directly downstream of the stall-capable pipeline stage. Accepts the 32-bit valid/stall/flush stream, applies programmable pseudo-random backpressure through its stall output, and accumulates a wrap-around checksum and transfer count. An in-order sequence checker flags words that break the +1 sequence and resynchronises after every upstream flush.

## Interface
- DATA_W, 32: stream data width.
- CNT_W, 16: accepted-word counter width.
- ECNT_W, 8: error counter width.
- LFSR_SEED, 16'hACE1: backpressure LFSR reset value; must be non-zero.

Ports:
- clk  input  1  clock.
- reset  input  1  reset, asynchronous, active-high.
- in_data  input  DATA_W  stream data from upstream stage.
- in_valid  input  1  upstream data valid.
- in_flush  input  1  upstream flush pulse.
- stall_o  output  1  backpressure to upstream; high = word not taken this cycle.
- stall_en  input  1  enables pseudo-random backpressure.
- stall_thresh  input  4  stall when LFSR[3:0] < stall_thresh; 0 = never, 15 = 15/16 of cycles.
- seq_base  input  DATA_W  expected value of the first word after reset/clear.
- clear  input  1  synchronous clear of statistics and checker.
- sum_o  output  DATA_W  running sum of accepted words, mod 2^DATA_W.
- count_o  output  CNT_W  accepted words, saturating.
- last_o  output  DATA_W  most recent accepted word.
- err_o  output  1  sticky sequence-error flag.
- err_cnt_o  output  ECNT_W  sequence errors, saturating.
- first_err_o  output  DATA_W  data of the first erroneous word.
- state_o  output  2  checker state (IDLE=0, RUN=1, RESYNC=2).

## Operation
- Transfer (xfer) = in_valid & !stall_o & !in_flush. Nothing else updates statistics.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. Shift left every cycle, new lsb = l[15]^l[13]^l[12]^l[10]. Runs regardless of stall_en.
- stall_o is registered: stall_o <= stall_en & (lfsr_next[3:0] < stall_thresh).
- On xfer: sum += in_data (wraps), count += 1 (holds at all-ones), last_o = in_data.
- Checker FSM, with expected register exp:
  - IDLE: on xfer, compare in_data with seq_base, set exp = in_data+1, go to RUN.
  - RUN: on xfer, compare in_data with exp, set exp = in_data+1. Resync to the received word so one glitch gives one error.
  - RESYNC: on xfer, no compare, set exp = in_data+1, go to RUN.
  - in_flush: RUN goes to RESYNC. IDLE and RESYNC are unchanged. Flush does not touch sum, count or errors.
- Mismatch: err_cnt += 1 (saturating). If err_o was 0, capture first_err_o = in_data. Then err_o = 1.
- clear: sum, count, last, err, err_cnt, first_err go to 0 and the FSM goes to IDLE. The LFSR and stall_o are unaffected.
- Priority: reset > clear > in_flush > xfer. Clear with xfer in the same cycle discards the word.

## Timing
- Reset values: stall_o=0, sum_o=0, count_o=0, last_o=0, err_o=0, err_cnt_o=0, first_err_o=0, state_o=IDLE, LFSR=LFSR_SEED.
- All outputs are registered. Statistics reflect an xfer one cycle after the accepting edge.
- A stall_en/stall_thresh change is visible on stall_o after one cycle.
- Upstream holds data while stall_o & in_valid, so a stalled word is taken on the first cycle with stall_o=0. No word is lost or duplicated.
- Reset mid-stream: all state returns to reset values immediately (asynchronous); the next word is checked against seq_base.
- Count/err_cnt at max: hold, no wrap. Sum at 0xFFFFFFFF + 1 gives 0.

## Structure
- Shared package pipeline_pkg:
  - DATA_W default.
  - checker state enum: IDLE/RUN/RESYNC.
  - LFSR seed and tap constants.
- Sub-module lfsr_stall_gen holds the LFSR and the stall_o register, with inputs stall_en and stall_thresh. The checker FSM and statistics stay in the top module.

## Test plan
- Reset, stall_en=0, seq_base=100, send 100..103 back-to-back -> stall_o stays 0, count_o=4, sum_o=406, last_o=103, err_o=0, state_o=RUN.
- stall_en=1, stall_thresh=8, send 1000 words 0..999 through an upstream stage -> count_o=1000, sum_o=499500, err_o=0, and stall_o duty is about 50%.
- Sequence 5,6,9,10 with seq_base=5 -> err_cnt_o=1, first_err_o=9, err_o=1, no further errors.
- Send 1,2, pulse in_flush, then send 50,51 -> state_o goes RESYNC then RUN, err_cnt_o=0, count_o=4, sum_o=104.
- In_flush and in_valid in the same cycle with data 7 -> no count change. Clear and in_valid in the same cycle -> all statistics 0, state_o=IDLE.
- Preload count_o to 0xFFFE (via 0xFFFE transfers or a force), then 3 transfers -> count_o=0xFFFF. Words 0xFFFFFFFF then 1 from sum 0 -> sum_o=0.
